// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- instruction decode stage with integrated GPR and FPR files.
//
// Accepts one instruction at a time. The sequence for each one is:
// accept (IDLE) -> DECODE -> ISSUE -> WAIT -> back to IDLE.
// In DECODE the register files are read and every decoded operand is
// registered. These operands then stay stable until the next issue.
//
// Ports:
//   clk, rstn                    clock and asynchronous active-low reset
//   inst_valid, inst, inst_pc    fetched instruction and its address
//   inst_ready                   high only while idle and out of reset
//   exec_enable                  one-cycle issue pulse to the execute stage
//   exec_done                    execute stage completion (used only in WAIT)
//   exec_command .. fmode2       registered decoded operands
//   wb_en, wb_fp, wb_rd, wb_data register write port (wb_fp selects the FPR)
// ---------------------------------------------------------------------------
module decode (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    input  logic [31:0] inst_pc,
    output logic        inst_ready,
    output logic        exec_enable,
    input  logic        exec_done,
    output logic [5:0]  exec_command,
    output logic [5:0]  alu_command,
    output logic [15:0] offset,
    output logic [31:0] pc,
    output logic [31:0] addr,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [4:0]  sh,
    output logic [4:0]  rd,
    output logic [4:0]  rs_no,
    output logic [4:0]  rt_no,
    output logic        fmode1,
    output logic        fmode2,
    input  logic        wb_en,
    input  logic        wb_fp,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0]  exec_command;
        logic [5:0]  alu_command;
        logic [15:0] offset;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [4:0]  rd;
        logic [4:0]  rs_no;
        logic [4:0]  rt_no;
        logic        fmode1;
        logic        fmode2;
    } dec_t;

    state_t      state_q, state_d;
    logic        exec_enable_q, exec_enable_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    dec_t        dec_q, dec_d, dec_new;

    logic [31:0] gpr_q [32];
    logic [31:0] fpr_q [32];

    // -----------------------------------------------------------------------
    // Register files. The GPR ignores writes to r0. Both files are cleared
    // by reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
                fpr_q[i] <= '0;
            end
        end else if (wb_en) begin
            if (wb_fp) begin
                fpr_q[wb_rd] <= wb_data;
            end else if (wb_rd != 5'd0) begin
                gpr_q[wb_rd] <= wb_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports with same-cycle write bypass. The GPR port indices are
    // inst[25:21] and inst[20:16]. The FPR port indices are inst[15:11]
    // (float rs) and inst[20:16].
    // -----------------------------------------------------------------------
    logic [4:0]  gidx_s, gidx_t, fidx_s, fidx_t;
    logic [31:0] gpr_rs, gpr_rt, fpr_rs, fpr_rt;

    always_comb begin
        gidx_s = inst_q[25:21];
        gidx_t = inst_q[20:16];
        fidx_s = inst_q[15:11];
        fidx_t = inst_q[20:16];

        gpr_rs = (gidx_s == 5'd0) ? 32'd0 : gpr_q[gidx_s];
        gpr_rt = (gidx_t == 5'd0) ? 32'd0 : gpr_q[gidx_t];
        fpr_rs = fpr_q[fidx_s];
        fpr_rt = fpr_q[fidx_t];

        if (wb_en && !wb_fp && wb_rd != 5'd0) begin
            if (wb_rd == gidx_s) gpr_rs = wb_data;
            if (wb_rd == gidx_t) gpr_rt = wb_data;
        end
        if (wb_en && wb_fp) begin
            if (wb_rd == fidx_s) fpr_rs = wb_data;
            if (wb_rd == fidx_t) fpr_rt = wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Field decode from the latched instruction
    // -----------------------------------------------------------------------
    logic [31:0] simm;
    logic [31:0] zimm;

    always_comb begin
        simm = {{16{inst_q[15]}}, inst_q[15:0]};
        zimm = {16'd0, inst_q[15:0]};

        dec_new              = '0;
        dec_new.exec_command = inst_q[31:26];
        dec_new.rs_no        = inst_q[25:21];
        dec_new.rt_no        = inst_q[20:16];
        dec_new.offset       = inst_q[15:0];
        dec_new.pc           = ipc_q;

        case (inst_q[31:26])
            6'b000000: begin                       // R-type
                dec_new.rd          = inst_q[15:11];
                dec_new.sh          = inst_q[10:6];
                dec_new.alu_command = inst_q[5:0];
                dec_new.rs          = gpr_rs;
                dec_new.rt          = gpr_rt;
            end
            6'b010001: begin                       // floating point
                dec_new.rs_no       = inst_q[15:11];
                dec_new.rd          = inst_q[10:6];
                dec_new.alu_command = inst_q[5:0];
                dec_new.fmode1      = 1'b1;
                dec_new.fmode2      = 1'b1;
                dec_new.rs          = fpr_rs;
                dec_new.rt          = fpr_rt;
            end
            6'b001000: begin                       // ADDI
                dec_new.rs = gpr_rs;
                dec_new.rt = simm;
                dec_new.rd = inst_q[20:16];
            end
            6'b001100, 6'b001101, 6'b001110: begin // ANDI / ORI / XORI
                dec_new.rs = gpr_rs;
                dec_new.rt = zimm;
                dec_new.rd = inst_q[20:16];
            end
            6'b000010, 6'b000011: begin            // J / JAL
                dec_new.addr = {ipc_q[31:28], inst_q[25:0], 2'b00};
            end
            6'b000100, 6'b000101, 6'b110010: begin // BEQ / BNE / BC
                dec_new.addr = {simm[29:0], 2'b00};
            end
            6'b100011, 6'b110001: begin            // LW / LF
                dec_new.addr = gpr_rs + simm;
                dec_new.rd   = inst_q[20:16];
            end
            6'b101011: begin                       // SW
                dec_new.addr = gpr_rs + simm;
                dec_new.rt   = gpr_rt;
            end
            6'b111001: begin                       // SF
                dec_new.addr   = gpr_rs + simm;
                dec_new.rt     = fpr_rt;
                dec_new.fmode2 = 1'b1;
            end
            6'b111111: begin                       // IN / OUT
                dec_new.alu_command = inst_q[5:0];
                dec_new.sh          = inst_q[10:6];
                dec_new.rd          = inst_q[15:11];
                dec_new.rs          = gpr_rs;
            end
            default: begin                         // unknown: opcode only
                dec_new              = '0;
                dec_new.exec_command = inst_q[31:26];
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        ipc_d         = ipc_q;
        exec_enable_d = 1'b0;
        dec_d         = dec_q;
        case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    inst_d  = inst;
                    ipc_d   = inst_pc;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_d         = dec_new;
                exec_enable_d = 1'b1;
                state_d       = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (exec_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            exec_enable_q <= 1'b0;
            inst_q        <= '0;
            ipc_q         <= '0;
            dec_q         <= '0;
        end else begin
            state_q       <= state_d;
            exec_enable_q <= exec_enable_d;
            inst_q        <= inst_d;
            ipc_q         <= ipc_d;
            dec_q         <= dec_d;
        end
    end

    // Gate ready with rstn so that it drops the moment reset asserts, even
    // though the state register already reads IDLE.
    assign inst_ready   = rstn && (state_q == S_IDLE);
    assign exec_enable  = exec_enable_q;
    assign exec_command = dec_q.exec_command;
    assign alu_command  = dec_q.alu_command;
    assign offset       = dec_q.offset;
    assign pc           = dec_q.pc;
    assign addr         = dec_q.addr;
    assign rs           = dec_q.rs;
    assign rt           = dec_q.rt;
    assign sh           = dec_q.sh;
    assign rd           = dec_q.rd;
    assign rs_no        = dec_q.rs_no;
    assign rt_no        = dec_q.rt_no;
    assign fmode1       = dec_q.fmode1;
    assign fmode2       = dec_q.fmode2;

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode -- self-checking bench for decode.
// It applies a table of directed vectors, then hand-written reset
// sequences, then randomized instructions. Every result is checked against
// a register-file model and an instruction-semantics model.
// ---------------------------------------------------------------------------
module tb_decode;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        exec_enable;
    logic        exec_done;
    logic [5:0]  exec_command, alu_command;
    logic [15:0] offset;
    logic [31:0] pc, addr, rs, rt;
    logic [4:0]  sh, rd, rs_no, rt_no;
    logic        fmode1, fmode2;
    logic        wb_en, wb_fp;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rstn(rstn),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .exec_enable(exec_enable), .exec_done(exec_done),
        .exec_command(exec_command), .alu_command(alu_command), .offset(offset),
        .pc(pc), .addr(addr), .rs(rs), .rt(rt),
        .sh(sh), .rd(rd), .rs_no(rs_no), .rt_no(rt_no),
        .fmode1(fmode1), .fmode2(fmode2),
        .wb_en(wb_en), .wb_fp(wb_fp), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    typedef struct packed {
        logic [5:0]  cmd;
        logic [5:0]  alu;
        logic [15:0] off;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [4:0]  rd;
        logic [4:0]  rs_no;
        logic [4:0]  rt_no;
        logic        f1;
        logic        f2;
    } outs_t;

    typedef struct {
        string       name;
        bit          pre_en;
        logic        pre_fp;
        logic [4:0]  pre_rd;
        logic [31:0] pre_data;
        bit          dec_en;
        logic        dec_fp;
        logic [4:0]  dec_rd;
        logic [31:0] dec_data;
        logic [31:0] i;
        logic [31:0] p;
        logic [5:0]  e_cmd;
        logic [5:0]  e_alu;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_addr;
        logic [4:0]  e_rd;
        logic        e_f2;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_fpr [32];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t dut_outs();
        return {exec_command, alu_command, offset, pc, addr, rs, rt,
                sh, rd, rs_no, rt_no, fmode1, fmode2};
    endfunction

    task automatic model_write(input logic fp, input logic [4:0] r, input logic [31:0] d);
        if (fp) m_fpr[r] = d;
        else if (r != 0) m_gpr[r] = d;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_gpr[k] = '0;
            m_fpr[k] = '0;
        end
    endtask

    // Instruction semantics, computed from the register-file model as it
    // stands after any same-cycle write has been applied.
    function automatic outs_t model(input logic [31:0] i, input logic [31:0] p);
        outs_t       o;
        logic [31:0] simm;
        int          ival;
        ival   = $signed(i[15:0]);
        simm   = ival;
        o      = '0;
        o.cmd  = i[31:26];
        o.rs_no = i[25:21];
        o.rt_no = i[20:16];
        o.off  = i[15:0];
        o.pc   = p;
        case (i[31:26])
            6'b000000: begin
                o.rd = i[15:11]; o.sh = i[10:6]; o.alu = i[5:0];
                o.rs = m_gpr[i[25:21]]; o.rt = m_gpr[i[20:16]];
            end
            6'b010001: begin
                o.rs_no = i[15:11]; o.rd = i[10:6]; o.alu = i[5:0];
                o.f1 = 1'b1; o.f2 = 1'b1;
                o.rs = m_fpr[i[15:11]]; o.rt = m_fpr[i[20:16]];
            end
            6'b001000: begin
                o.rs = m_gpr[i[25:21]]; o.rt = simm; o.rd = i[20:16];
            end
            6'b001100, 6'b001101, 6'b001110: begin
                o.rs = m_gpr[i[25:21]]; o.rt = 32'(i[15:0]); o.rd = i[20:16];
            end
            6'b000010, 6'b000011:
                o.addr = (p & 32'hF000_0000) + 32'(i[25:0]) * 4;
            6'b000100, 6'b000101, 6'b110010:
                o.addr = simm * 4;
            6'b100011, 6'b110001: begin
                o.addr = m_gpr[i[25:21]] + simm; o.rd = i[20:16];
            end
            6'b101011: begin
                o.addr = m_gpr[i[25:21]] + simm; o.rt = m_gpr[i[20:16]];
            end
            6'b111001: begin
                o.addr = m_gpr[i[25:21]] + simm; o.rt = m_fpr[i[20:16]]; o.f2 = 1'b1;
            end
            6'b111111: begin
                o.alu = i[5:0]; o.sh = i[10:6]; o.rd = i[15:11];
                o.rs = m_gpr[i[25:21]];
            end
            default: begin
                o = '0;
                o.cmd = i[31:26];
            end
        endcase
        return o;
    endfunction

    task automatic idle_write(input logic fp, input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_fp = fp; wb_rd = r; wb_data = d;
        model_write(fp, r, d);
        tick();
        wb_en = 1'b0;
    endtask

    // Runs one full instruction from IDLE back to IDLE and returns the
    // operands sampled in the issue cycle. The instruction can optionally
    // carry a register write during its DECODE cycle, and exec_done can be
    // held low for wc extra WAIT cycles.
    task automatic run_inst(input string name, input logic [31:0] i, input logic [31:0] p,
                            input bit de, input logic dfp, input logic [4:0] drd,
                            input logic [31:0] dd, input int wc, output outs_t got);
        outs_t exp;
        logic [31:0] r;
        check({name, "_ready"}, 256'(inst_ready), 256'(1));
        inst_valid = 1'b1; inst = i; inst_pc = p;
        tick();                                   // DECODE
        inst_valid = 1'($urandom); inst = $urandom; inst_pc = $urandom;
        exec_done = 1'($urandom);
        if (de) begin
            wb_en = 1'b1; wb_fp = dfp; wb_rd = drd; wb_data = dd;
            model_write(dfp, drd, dd);
        end
        exp = model(i, p);
        tick();                                   // ISSUE
        wb_en = 1'b0;
        exec_done = 1'($urandom);
        got = dut_outs();
        check({name, "_issue"}, 256'({exec_enable, inst_ready}), 256'(2'b10));
        check({name, "_outs"}, 256'(got), 256'(exp));
        tick();                                   // WAIT
        exec_done = 1'b0;
        if (($urandom % 2) == 0) begin
            r = $urandom;
            wb_en = 1'b1; wb_fp = r[5]; wb_rd = r[4:0]; wb_data = $urandom;
            model_write(wb_fp, wb_rd, wb_data);
        end
        for (int k = 0; k < wc; k++) begin
            check({name, "_wait"}, 256'({exec_enable, inst_ready}), 256'(2'b00));
            tick();
            wb_en = 1'b0;
        end
        exec_done = 1'b1; inst_valid = 1'b0;
        tick();                                   // IDLE
        wb_en = 1'b0; exec_done = 1'b0;
        check({name, "_done"}, 256'({exec_enable, inst_ready}), 256'(2'b01));
        check({name, "_hold"}, 256'(dut_outs()), 256'(exp));
    endtask

    vec_t        vecs [9];
    logic [5:0]  ops  [16];
    outs_t       got;

    initial begin
        vecs[0] = '{"addi",  1, 0, 5'd2, 32'h5,        0, 0, 5'd0, 32'h0,
                    32'h2043FFFF, 32'h0000_1000, 6'h08, 6'h00, 32'h5, 32'hFFFF_FFFF, 32'h0, 5'd3, 0};
        vecs[1] = '{"add_r0", 1, 0, 5'd0, 32'h1234,    0, 0, 5'd0, 32'h0,
                    32'h00000820, 32'h0000_1004, 6'h00, 6'h20, 32'h0, 32'h0, 32'h0, 5'd1, 0};
        vecs[2] = '{"lw_byp", 0, 0, 5'd0, 32'h0,       1, 0, 5'd4, 32'hA,
                    32'h8C850008, 32'h0000_1008, 6'h23, 6'h00, 32'h0, 32'h0, 32'h12, 5'd5, 0};
        vecs[3] = '{"jal",   0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,
                    32'h0C000100, 32'h4000_0010, 6'h03, 6'h00, 32'h0, 32'h0, 32'h4000_0400, 5'd0, 0};
        vecs[4] = '{"fadd",  1, 1, 5'd0, 32'h3F80_0000, 1, 1, 5'd2, 32'h4000_0000,
                    32'h44020100, 32'h0000_2000, 6'h11, 6'h00, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd4, 1};
        vecs[5] = '{"beq",   0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,
                    32'h1000FFFF, 32'h0000_2004, 6'h04, 6'h00, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 0};
        vecs[6] = '{"unknown", 0, 0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,
                    32'hF0FFFFFF, 32'h0000_2008, 6'h3C, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 0};
        vecs[7] = '{"sf",    0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,
                    32'hE4420004, 32'h0000_200C, 6'h39, 6'h00, 32'h0, 32'h4000_0000, 32'h9, 5'd0, 1};
        vecs[8] = '{"andi",  0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,
                    32'h30468001, 32'h0000_2010, 6'h0C, 6'h00, 32'h5, 32'h0000_8001, 32'h0, 5'd6, 0};

        ops = '{6'b000000, 6'b010001, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
                6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b110010, 6'b100011,
                6'b110001, 6'b101011, 6'b111001, 6'b111111};

        model_reset();
        rstn = 1'b0; inst_valid = 1'b0; inst = '0; inst_pc = '0;
        exec_done = 1'b0; wb_en = 1'b0; wb_fp = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset state
        tick(); tick();
        check("rst_ready_enable", 256'({inst_ready, exec_enable}), 256'(2'b00));
        check("rst_outs", 256'(dut_outs()), 256'(0));
        rstn = 1'b1;
        #1;
        check("release_ready", 256'(inst_ready), 256'(1));
        tick();

        // Directed table
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].pre_en) idle_write(vecs[v].pre_fp, vecs[v].pre_rd, vecs[v].pre_data);
            run_inst(vecs[v].name, vecs[v].i, vecs[v].p, vecs[v].dec_en, vecs[v].dec_fp,
                     vecs[v].dec_rd, vecs[v].dec_data, v % 3, got);
            check({vecs[v].name, "_fields"},
                  256'({got.cmd, got.alu, got.rs, got.rt, got.addr, got.rd, got.f2}),
                  256'({vecs[v].e_cmd, vecs[v].e_alu, vecs[v].e_rs, vecs[v].e_rt,
                        vecs[v].e_addr, vecs[v].e_rd, vecs[v].e_f2}));
        end

        // Long execute: exec_done held low for 20 cycles
        run_inst("long_wait", 32'h2043FFFF, 32'h0000_3000, 0, 0, 5'd0, 32'h0, 20, got);

        // Reset while waiting for exec_done
        inst_valid = 1'b1; inst = 32'h00430820; inst_pc = 32'h0000_4000;
        tick(); inst_valid = 1'b0;                // DECODE
        tick();                                   // ISSUE
        tick();                                   // WAIT
        #2 rstn = 1'b0;
        #1;
        check("rst_wait_outs", 256'(dut_outs()), 256'(0));
        check("rst_wait_flags", 256'({inst_ready, exec_enable}), 256'(2'b00));
        model_reset();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exec_done = 1'($urandom);
            tick();
            check("post_rst_wait", 256'({exec_enable, inst_ready}), 256'(2'b01));
        end
        exec_done = 1'b0;

        // Reset during the issue cycle
        idle_write(1'b0, 5'd2, 32'h77);
        inst_valid = 1'b1; inst = 32'h00430820; inst_pc = 32'h0000_5000;
        tick(); inst_valid = 1'b0;                // DECODE
        tick();                                   // ISSUE
        check("pre_rst_issue", 256'(exec_enable), 256'(1));
        #2 rstn = 1'b0;
        #1;
        check("rst_issue_enable", 256'({exec_enable, inst_ready}), 256'(2'b00));
        check("rst_issue_outs", 256'(dut_outs()), 256'(0));
        model_reset();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_issue", 256'({exec_enable, inst_ready}), 256'(2'b01));
        end

        // Register files must read back as cleared after reset
        run_inst("regs_cleared", 32'h00430820, 32'h0000_6000, 0, 0, 5'd0, 32'h0, 0, got);
        run_inst("fregs_cleared", 32'h44020100, 32'h0000_6004, 0, 0, 5'd0, 32'h0, 0, got);

        // Randomized instructions against the model
        for (int n = 0; n < 250; n++) begin
            logic [31:0] r, ri;
            int          oi;
            r = $urandom;
            if (r[0]) idle_write(r[1], r[6:2], $urandom);
            ri = $urandom;
            oi = $urandom_range(0, 16);
            if (oi < 16) ri[31:26] = ops[oi];
            r = $urandom;
            run_inst("rand", ri, $urandom, r[0], r[1], r[6:2], $urandom, int'(r[9:8]), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 inst_valid  in  1 / inst  in  32 / inst_pc  in  32  fetched instruction and its address.
REQ-004 inst_ready  out  1  decoder accepts an instruction this cycle.
REQ-005 exec_enable  out  1  one-cycle issue pulse to execute stage.
REQ-006 exec_done  in  1  execute stage finished the issued instruction.
REQ-007 exec_command, alu_command  out  6 each / offset  out  16 / pc, addr, rs, rt  out  32 each / sh, rd, rs_no, rt_no  out  5 each / fmode1, fmode2  out  1 each  decoded operands, stable from issue until next issue.
REQ-008 wb_en  in  1 / wb_fp  in  1 / wb_rd  in  5 / wb_data  in  32  register write port (wb_fp=1 selects FPR).

Function
REQ-009 Shall hold 32x32 GPR file (r0 reads 0, writes ignored) and 32x32 FPR file (f0 writable).
REQ-010 FSM states IDLE, DECODE, ISSUE, WAIT; inst_ready=1 only in IDLE.
REQ-011 IDLE: inst_valid=1 -> latch inst, inst_pc, go DECODE; else stay.
REQ-012 DECODE: read register files, register all REQ-007 outputs, go ISSUE.
REQ-013 ISSUE: exec_enable=1 exactly one cycle, go WAIT.
REQ-014 WAIT: exec_done=1 -> IDLE; exec_done outside WAIT ignored.
REQ-015 Minimum accept-to-accept period: 4 cycles (accept, DECODE, ISSUE, WAIT with done).
REQ-016 Fields: op=inst[31:26] -> exec_command; rs_no=inst[25:21]; rt_no=inst[20:16]; offset=inst[15:0]; pc=latched inst_pc.
REQ-017 op 000000: rd=inst[15:11], sh=inst[10:6], alu_command=inst[5:0], rs/rt from GPR.
REQ-018 op 010001 (float): rs_no=inst[15:11], rt_no=inst[20:16], rd=inst[10:6], alu_command=inst[5:0], fmode1=fmode2=1, rs/rt from FPR.
REQ-019 ADDI (001000): rt=sign-extended offset; ANDI/ORI/XORI (001100/001101/001110): rt=zero-extended offset; rd=inst[20:16].
REQ-020 J/JAL (000010/000011): addr={inst_pc[31:28], inst[25:0], 2'b00}.
REQ-021 BEQ/BNE/BC (000100/000101/110010): addr=sign-extended offset shifted left 2 (relative, 32-bit wrap).
REQ-022 LW/LF (100011/110001): addr=GPR[rs_no]+sign-extended offset (mod 2^32), rd=inst[20:16], fmode2=0.
REQ-023 SW (101011): addr as REQ-022, rt=GPR[rt_no]; SF (111001): rt=FPR[rt_no], fmode2=1.
REQ-024 IN/OUT (111111): alu_command=inst[5:0], sh=inst[10:6], rd=inst[15:11], rs=GPR[rs_no].
REQ-025 Unlisted fields and all fields of unknown opcodes shall be 0 except exec_command; issued normally.
REQ-026 Write: wb_en=1 writes wb_data to selected file at wb_rd on that edge, in any state.
REQ-027 Bypass: read in DECODE whose file/index equals a same-cycle write returns wb_data (never for r0).
REQ-028 Writes after DECODE do not alter held rs/rt/addr.
REQ-029 inst, inst_pc ignored outside IDLE.

Reset
REQ-030 rstn=0 forces IDLE, inst_ready=0 while asserted, exec_enable=0, all REQ-007 outputs 0, all registers 0, immediately (asynchronous).
REQ-031 Reset mid-WAIT or mid-ISSUE abandons the instruction; no issue pulse after release.
REQ-032 First cycle after release: IDLE, inst_ready=1.

Verification
REQ-033 GPR r2=5 via wb; inst ADDI r3,r2,-1 (0x2043FFFF) -> issue: exec_command=001000, rs=5, rt=0xFFFFFFFF, rd=3.
REQ-034 wb_en r0=0x1234 then R-type ADD r1,r0,r0 -> rs=0, rt=0.
REQ-035 wb write r4=0xA in DECODE cycle of LW r5,8(r4) -> addr=0x12, rd=5, fmode2=0.
REQ-036 inst_pc=0x40000010, JAL target field 0x100 -> addr=0x40000400.
REQ-037 exec_done held low 20 cycles after issue -> inst_ready=0, no second exec_enable; done -> inst_ready=1 next cycle.
REQ-038 rstn low during WAIT -> outputs 0 immediately; after release no exec_enable without new inst_valid.
